// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the iterative RV32M multiply unit.
//   - XLEN / ITERS : operand width and number of shift-add iterations
//   - mul_op_e     : operation encoding (RV32M funct3[1:0])
//   - mul_state_e  : sequencer state encoding
//   - mag32        : magnitude of a 32-bit operand, optionally signed
package mul_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_FIN  = 2'b11
    } mul_state_e;

    // -2^31 maps to 0x80000000, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/cla_add32.sv
// cla_add32: 32-bit adder built from eight rippled 4-bit carry-lookahead slices.
//   a, b  : addends
//   cin   : carry in
//   sum   : 32-bit sum
//   cout  : carry out of bit 31
module cla_add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [8:0] c;
    assign c[0] = cin;

    for (genvar s = 0; s < 8; s++) begin : g_slice
        logic [3:0] g, p;
        logic [4:0] cc;

        assign g     = a[4*s +: 4] & b[4*s +: 4];
        assign p     = a[4*s +: 4] ^ b[4*s +: 4];
        assign cc[0] = c[s];
        // Fully expanded lookahead inside the slice; slices chain via c[].
        assign cc[1] = g[0] | (p[0] & cc[0]);
        assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
        assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                     | (p[2] & p[1] & p[0] & cc[0]);
        assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0])
                     | (p[3] & p[2] & p[1] & p[0] & cc[0]);

        assign sum[4*s +: 4] = p ^ cc[3:0];
        assign c[s+1]        = cc[4];
    end

    assign cout = c[8];

endmodule

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are converted to magnitudes on acceptance, multiplied unsigned over
// ITERS cycles, and the sign is reapplied in a single fix-up cycle.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request pulse, sampled only while idle
//   op     : operation (mul_op_e encoding)
//   a, b   : rs1 / rs2 operands
//   busy   : request in flight (CALC, FIX, FIN)
//   done   : one-cycle pulse, result valid
//   result : low or high product word, held until the next operation
module mul_unit
    import mul_pkg::*;
#(
    parameter int XLEN  = mul_pkg::XLEN,   // only 32 supported
    parameter int ITERS = mul_pkg::ITERS   // must equal XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(ITERS);

    mul_state_e       state;
    mul_op_e          op_q;
    logic [31:0]      mcand;
    logic [31:0]      prod_hi;
    logic [31:0]      prod_lo;   // holds the multiplier, shifted out as product bits shift in
    logic             neg;
    logic [CNT_W-1:0] cnt;

    // Per-op signedness of the incoming operands.
    logic a_sgn, b_sgn;
    assign a_sgn = (op == OP_MULH) || (op == OP_MULHSU);
    assign b_sgn = (op == OP_MULH);

    // Partial-product add: addend gated by the current multiplier LSB.
    logic [31:0] add_sum;
    logic        add_cout;

    cla_add32 u_add (
        .a    (prod_hi),
        .b    (prod_lo[0] ? mcand : 32'd0),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    logic [63:0] prod_fix;
    assign prod_fix = neg ? (~{prod_hi, prod_lo} + 64'd1) : {prod_hi, prod_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= OP_MUL;
            mcand   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q    <= mul_op_e'(op);
                        mcand   <= mag32(a, a_sgn);
                        prod_lo <= mag32(b, b_sgn);
                        prod_hi <= '0;
                        neg     <= (a_sgn & a[31]) ^ (b_sgn & b[31]);
                        cnt     <= CNT_W'(ITERS - 1);
                        busy    <= 1'b1;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Shift {carry, sum, multiplier} right by one.
                    {prod_hi, prod_lo} <= {add_cout, add_sum, prod_lo[31:1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= ST_FIX;
                end
                ST_FIX: begin
                    result <= (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
                    done   <= 1'b1;
                    state  <= ST_FIN;
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed vectors with a scoreboard queue; a monitor branch pops
// and checks result and DONE timing whenever the unit pulses done.
module tb_mul_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy, done;
    logic [31:0] result;

    mul_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] exp;
        int          exp_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Called at a negedge: start is sampled at the next edge E (= cyc+1);
    // done must then be visible at the negedge where cyc = E+33, i.e. the
    // 34th edge after E samples it high.
    task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] e);
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back('{exp: e, exp_cyc: cyc + 34, name: nm});
    endtask

    task automatic wait_drain(input string nm);
        bit ok;
        ok = 1'b0;
        repeat (100) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({nm, " drain"}, 32'(ok), 32'd1);
        if (!ok) sb.delete();
    endtask

    localparam int NV = 12;
    logic [1:0]  v_op [NV] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b10,
                               2'b01, 2'b01, 2'b11, 2'b00, 2'b10, 2'b10};
    logic [31:0] v_a  [NV] = '{32'h00000007, 32'h80000000, 32'h00000007, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000000,
                               32'h12345678, 32'h12345678, 32'h80000000, 32'h00000003};
    logic [31:0] v_b  [NV] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFB,
                               32'h00000010, 32'h00000010, 32'h00000002, 32'h80000000};
    logic [31:0] v_e  [NV] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                               32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                               32'h00000001, 32'h23456780, 32'hFFFFFFFF, 32'h00000001};

    initial begin
        fork
            // Monitor: every done pulse must match the oldest expectation.
            forever begin
                @(negedge clk);
                if (rst_n && done) begin
                    if (sb.size() == 0) begin
                        check("unexpected done", 32'(done), 32'd0);
                    end else begin
                        exp_t t;
                        t = sb.pop_front();
                        check({t.name, " result"}, result, t.exp);
                        check({t.name, " latency"}, 32'(cyc), 32'(t.exp_cyc));
                    end
                end
            end
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);

        // Directed vectors; the first start coincides with reset release.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (i != 0) @(negedge clk);
            issue(nm, v_op[i], v_a[i], v_b[i], v_e[i]);
            @(negedge clk);
            start = 1'b0;
            if (i == 0) begin
                repeat (10) @(negedge clk);
                check("busy mid-op", 32'(busy), 32'd1);
            end
            wait_drain(nm);
            @(negedge clk);
            check({nm, " idle busy"}, 32'(busy), 32'd0);
            check({nm, " result hold"}, result, v_e[i]);
        end

        // Start pulses during busy are ignored; start held through FIN is
        // only taken on the following idle cycle.
        begin
            bit seen;
            @(negedge clk);
            issue("ovl first", 2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            op = 2'b11; a = 32'h1; b = 32'h1; start = 1'b1;   // cycle 5
            @(negedge clk);
            start = 1'b0;
            repeat (14) @(negedge clk);
            op = 2'b01; a = 32'h2; b = 32'h3; start = 1'b1;   // cycle 20
            @(negedge clk);
            start = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("ovl done seen", 32'(seen), 32'd1);
            // Now in FIN: assert start here and keep it through the next edge.
            op = 2'b11; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
            @(negedge clk);
            issue("b2b second", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
            @(negedge clk);
            start = 1'b0;
            wait_drain("b2b second");
        end

        // Reset in the middle of CALC aborts the operation.
        @(negedge clk);
        op = 2'b01; a = 32'h5; b = 32'h3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue("post reset", 2'b00, 32'h00000006, 32'h00000007, 32'h0000002A);
        @(negedge clk);
        start = 1'b0;
        wait_drain("post reset");
        repeat (40) @(negedge clk);
        check("sb empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 Parameter ITERS, default 32, number of shift-add iterations; SHALL equal XLEN.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 START  input  1  request pulse; sampled only in IDLE.
REQ-006 OP  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RV32M funct3[1:0]).
REQ-007 A  input  32  multiplicand (rs1); signed for MULH/MULHSU, unsigned for MULHU.
REQ-008 B  input  32  multiplier (rs2); signed for MULH only.
REQ-009 BUSY  output  1  high from the cycle after START is accepted until DONE deasserts.
REQ-010 DONE  output  1  one-cycle pulse; RESULT valid in that cycle.
REQ-011 RESULT  output  32  low word (MUL) or high word (MULH/MULHSU/MULHU) of the 64-bit product.

Function
REQ-012 FSM states: IDLE, CALC, FIX, FIN; reset state IDLE.
REQ-013 IDLE: on START=1, latch OP, |A|, |B| (per-op signedness), NEG = sign(A) xor sign(B) for signed cases; zero the 64-bit accumulator; count=ITERS-1; go to CALC.
REQ-014 CALC: each cycle, if multiplier LSB=1, add multiplicand to accumulator upper 32 bits via 32-bit CLA adder, carry-out kept as bit 64; shift {carry, acc, mplier} right by 1; decrement count.
REQ-015 CALC -> FIX when count=0 after its update cycle (exactly 32 CALC cycles).
REQ-016 FIX: if NEG=1, two's-complement negate the 64-bit product; select high or low word per OP into RESULT register; go to FIN.
REQ-017 FIN: DONE=1 for exactly one cycle; next state IDLE.
REQ-018 Latency: DONE high exactly 34 rising edges after the edge that sampled START=1.
REQ-019 RESULT holds its value after FIN until the next FIX writes it.
REQ-020 START while BUSY=1 is ignored; no queueing; OP/A/B changes during BUSY have no effect.
REQ-021 START asserted in the FIN cycle is ignored; START on the first IDLE cycle after FIN is accepted (back-to-back throughput 35 cycles).
REQ-022 Magnitude of -2^31 is 2^31 (unsigned 32-bit 0x80000000); no overflow flag exists.
REQ-023 Zero operand: full 32 iterations still run; result 0, NEG irrelevant (negating 0 yields 0).
REQ-024 BUSY=1 in CALC, FIX and FIN; 0 in IDLE.

Reset
REQ-025 RST_N low: state IDLE, BUSY=0, DONE=0, RESULT=0x00000000, accumulator, count and NEG cleared, asynchronously.
REQ-026 Reset asserted mid-operation aborts it; no DONE is produced for the aborted request.
REQ-027 First START after RST_N deasserts is accepted on the first rising edge where RST_N is high.

Structure
REQ-028 Package mul_pkg SHALL hold the OP encodings, the FSM state encoding and ITERS.
REQ-029 One sub-module cla_add32: 32-bit adder of eight chained 4-bit CLA slices with CIN/COUT, used for the CALC add; FIX negation may use a separate incrementer.

Verification
REQ-030 OP=00, A=7, B=0xFFFFFFFD (-3) -> DONE at edge 34, RESULT=0xFFFFFFEB.
REQ-031 OP=01, A=0x80000000, B=0x80000000 -> RESULT=0x40000000; OP=01, A=7, B=-3 -> RESULT=0xFFFFFFFF.
REQ-032 OP=11, A=B=0xFFFFFFFF -> RESULT=0xFFFFFFFE; OP=00 same operands -> RESULT=0x00000001.
REQ-033 OP=10, A=0xFFFFFFFF (-1), B=0xFFFFFFFF (unsigned) -> RESULT=0xFFFFFFFF.
REQ-034 START pulsed at cycles 5 and 20 of a running op -> single DONE, RESULT from first operands; START in FIN ignored, START next cycle accepted.
REQ-035 RST_N low at CALC cycle 10 -> BUSY=0, DONE never pulses, RESULT=0; new START after release completes normally in 34 cycles.
